mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RISC-V-lite pipeline, directly downstream of the execute stage. It consumes the EX/MEM pipeline registers (ALU result, store data, NPC+4, control word, destination), drives a request/grant/rvalid data-memory port with byte-lane steering and load extension, and stalls the pipeline while an access is outstanding. It owns the MEM/WB pipeline registers and provides the final write-back value, which is also the MEM/WB forwarding source.

## Interface
- N, 32, datapath width (fixed at 32 for byte-lane logic)
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- pipe_en  in  1  global pipeline enable from the hazard unit; must be low whenever stall is high
- ALUres  in  N  EX/MEM ALU result; effective address for loads and stores
- Bout  in  N  EX/MEM store data
- NPC4_IN  in  N  EX/MEM PC+4
- cwMEM  in  7  [6] mem_rd, [5] mem_wr, [4:3] size (00 byte, 01 half, 10 word, 11 treated as word), [2] unsigned load, [1:0] wb_sel (00 none, 01 ALU, 10 MEM, 11 NPC4)
- Rdest_in  in  N  EX/MEM destination, passed through
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  N  word-aligned address {ALUres[N-1:2],2'b00}
- dmem_wdata  out  N  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid this cycle
- dmem_rdata  in  N  load data word
- stall  out  1  access outstanding; EX/MEM and earlier must hold
- wb_data  out  N  MEM/WB write-back value
- wb_rdest  out  N  MEM/WB destination
- wb_en  out  1  MEM/WB register-file write enable
- misaligned  out  1  MEM/WB flag: access suppressed for misalignment

## Operation
- Op present when mem_rd or mem_wr is set; both set is treated as a load.
- Misaligned: half with ALUres[0]=1, or word with ALUres[1:0]≠0. No request is issued, there is no stall, and the instruction retires with wb_en=0 and misaligned=1.
- Store lanes: byte → wdata={4{Bout[7:0]}}, be=0001<<ALUres[1:0]. Half → wdata={2{Bout[15:0]}}, be=0011<<(2·ALUres[1]). Word → wdata=Bout, be=1111. Loads drive be=1111, and the load data word is dmem_rdata.
- Load extension: shift the data word right by 8·ALUres[1:0]. Byte/half results are zero-extended if unsigned, sign-extended otherwise.
- FSM states:
  - IDLE: dmem_req=op&aligned.
    - Store with gnt: done, stall=0.
    - Load with gnt: go to WAIT_R, stall=1.
    - No gnt: go to REQ, stall=1.
  - REQ: req held with addr/we/wdata/be stable until gnt.
    - Store: gnt → go to IDLE, stall=0 that cycle.
    - Load: gnt → go to WAIT_R, stall=1.
  - WAIT_R: req=0. stall=!dmem_rvalid. On rvalid, the extended data is latched into the load buffer and the FSM goes to IDLE.
- Completion-cycle data is selected combinationally: the extended dmem_rdata when rvalid is high, otherwise the load buffer.
- Write-back mux: wb_sel 01 → ALUres, 10 → loaded data, 11 → NPC4_IN, 00 → don't-care with wb_en=0.
- MEM/WB update:
  - pipe_en=1 and stall=0: capture the mux output, Rdest_in, wb_en=(wb_sel≠00)&!misaligned, and misaligned.
  - stall=1: insert a bubble (wb_en=0, misaligned=0); data/rdest hold.
  - pipe_en=0 and stall=0: hold all MEM/WB registers.

## Timing
- Reset (asynchronous): FSM→IDLE, load buffer=0, and wb_data, wb_rdest, wb_en, misaligned all 0. dmem_req=0 while rst is high.
- stall, dmem_req, dmem_addr, dmem_we, dmem_wdata, and dmem_be are combinational from state and inputs. The stall→pipe_en path must close in one cycle.
- Best case: a store granted in the IDLE cycle costs 0 stall cycles; a load costs 1 (gnt, then rvalid at the earliest the next cycle).
- MEM/WB outputs appear 1 cycle after the completion edge.
- A request is issued at most once per instruction. Because EX/MEM advances on the completion cycle, IDLE only ever sees fresh instructions.
- rvalid outside WAIT_R is ignored. gnt while req=0 is ignored.
- Reset mid-access returns the FSM to IDLE and abandons the access; the memory must tolerate this.

## Test plan
- Word load at 0x100, gnt in the request cycle, rvalid next cycle with 0xDEADBEEF, wb_sel=10 → stall high 1 cycle; wb_data=0xDEADBEEF, wb_en=1 one cycle after rvalid.
- Signed byte load at 0x103 with rdata=0x80112233 → wb_data=0xFFFFFF80. Unsigned → 0x00000080. Half load at 0x102 signed → 0xFFFF8011.
- Half store at 0x206 with Bout=0x0000ABCD and gnt withheld 3 cycles → req held stable for 4 cycles; wdata=0xABCDABCD, be=1100; stall=1 for 3 cycles, 0 on the gnt cycle; 3 bubbles with wb_en=0.
- Word load at 0x101 → no dmem_req, no stall; next cycle misaligned=1, wb_en=0.
- Back-to-back store then load, both granted immediately, rvalid after 2 cycles → exactly two requests; the load retires with the correct data; no duplicate request.
- rst asserted while in WAIT_R → all outputs 0 immediately; after release, dmem_req for the next op only, and a stale rvalid is ignored.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: request/grant/rvalid handshake with
// byte-lane write data and byte enables. The pipeline stage is the master,
// the data memory (or its bus adapter) is the slave.
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the RISC-V-lite pipeline. Consumes the EX/MEM
// registers, runs the request/grant/rvalid data-memory handshake with
// byte-lane steering and load extension, stalls upstream while an access is
// outstanding, and owns the MEM/WB registers that feed write-back and the
// MEM/WB forwarding path. The byte-lane logic assumes DATA_W = 32.
module mem_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_en,
    input  logic [DATA_W-1:0] ALUres,
    input  logic [DATA_W-1:0] Bout,
    input  logic [DATA_W-1:0] NPC4_IN,
    input  logic [6:0]        cwMEM,
    input  logic [DATA_W-1:0] Rdest_in,
    mem_stage_if.master       dmem,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] wb_rdest,
    output logic              wb_en,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2
    } state_t;

    // Load extension: bring the addressed lane down to bit 0, then zero- or
    // sign-extend byte/half results. Words pass through (offset is 0 when
    // aligned).
    function automatic logic [DATA_W-1:0] f_load_ext(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic [1:0]        lo,
        input logic              uns
    );
        logic [DATA_W-1:0] shifted;
        logic signed [7:0]  sbyte;
        logic signed [15:0] shalf;
        shifted = word >> {lo, 3'b000};
        sbyte   = $signed(shifted[7:0]);
        shalf   = $signed(shifted[15:0]);
        case (size)
            2'b00:   f_load_ext = uns ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                      : DATA_W'(sbyte);
            2'b01:   f_load_ext = uns ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                      : DATA_W'(shalf);
            default: f_load_ext = shifted;
        endcase
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick
    // the destination bytes.
    function automatic logic [DATA_W-1:0] f_store_wdata(
        input logic [1:0]        size,
        input logic [DATA_W-1:0] data
    );
        case (size)
            2'b00:   f_store_wdata = {4{data[7:0]}};
            2'b01:   f_store_wdata = {2{data[15:0]}};
            default: f_store_wdata = data;
        endcase
    endfunction

    function automatic logic [3:0] f_store_be(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            2'b00:   f_store_be = 4'b0001 << lo;
            2'b01:   f_store_be = 4'b0011 << {lo[1], 1'b0};
            default: f_store_be = 4'b1111;
        endcase
    endfunction

    // Control word decode
    logic       mem_rd, mem_wr, uns_ld;
    logic [1:0] size, wb_sel, lo;
    logic       is_load, is_store, op, mis_now;

    assign mem_rd   = cwMEM[6];
    assign mem_wr   = cwMEM[5];
    assign size     = cwMEM[4:3];
    assign uns_ld   = cwMEM[2];
    assign wb_sel   = cwMEM[1:0];
    assign lo       = ALUres[1:0];
    assign is_load  = mem_rd;
    assign is_store = mem_wr & ~mem_rd;
    assign op       = mem_rd | mem_wr;
    assign mis_now  = op & (((size == 2'b01) & lo[0]) |
                            (size[1] & (lo != 2'b00)));

    state_t            state;
    logic [DATA_W-1:0] load_buf;
    logic              req;
    logic [DATA_W-1:0] ext_rdata, load_data, wb_mux;

    // MEM/WB pipeline registers
    logic [DATA_W-1:0] wb_data_p1, wb_rdest_p1;
    logic              vld_p1, mis_p1;

    assign ext_rdata = f_load_ext(dmem.dmem_rdata, size, lo, uns_ld);
    assign load_data = (state == S_WAIT_R && dmem.dmem_rvalid) ? ext_rdata : load_buf;

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = is_store;
    assign dmem.dmem_addr  = {ALUres[DATA_W-1:2], 2'b00};
    assign dmem.dmem_wdata = f_store_wdata(size, Bout);
    assign dmem.dmem_be    = is_store ? f_store_be(size, lo) : 4'b1111;

    // Request and stall are combinational so the hazard unit can drop
    // pipe_en in the same cycle; both are forced low while in reset.
    always_comb begin
        req   = 1'b0;
        stall = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    req   = op & ~mis_now;
                    stall = req & ~(is_store & dmem.dmem_gnt);
                end
                S_REQ: begin
                    req   = 1'b1;
                    stall = ~(is_store & dmem.dmem_gnt);
                end
                S_WAIT_R: begin
                    stall = ~dmem.dmem_rvalid;
                end
                default: begin
                    req   = 1'b0;
                    stall = 1'b0;
                end
            endcase
        end
    end

    // Access FSM: one request per instruction, then wait for load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            load_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (dmem.dmem_gnt) state <= is_load ? S_WAIT_R : S_IDLE;
                        else               state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem.dmem_gnt) state <= is_load ? S_WAIT_R : S_IDLE;
                end
                S_WAIT_R: begin
                    if (dmem.dmem_rvalid) begin
                        load_buf <= ext_rdata;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-back source select; wb_sel 00 is don't-care and reuses ALUres.
    always_comb begin
        case (wb_sel)
            2'b10:   wb_mux = load_data;
            2'b11:   wb_mux = NPC4_IN;
            default: wb_mux = ALUres;
        endcase
    end

    // MEM -> WB boundary: capture on advance, bubble on stall, hold when frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_p1  <= '0;
            wb_rdest_p1 <= '0;
            vld_p1      <= 1'b0;
            mis_p1      <= 1'b0;
        end else if (stall) begin
            vld_p1 <= 1'b0;
            mis_p1 <= 1'b0;
        end else if (pipe_en) begin
            wb_data_p1  <= wb_mux;
            wb_rdest_p1 <= Rdest_in;
            vld_p1      <= (wb_sel != 2'b00) & ~mis_now;
            mis_p1      <= mis_now;
        end
    end

    assign wb_data    = wb_data_p1;
    assign wb_rdest   = wb_rdest_p1;
    assign wb_en      = vld_p1;
    assign misaligned = mis_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scripted memory responses per scenario, expected
// MEM/WB results queued when an instruction is driven and compared when it
// retires.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_en;
    logic [31:0] alu, bout, npc4, rdest;
    logic [6:0]  cw;
    logic        stall, wb_en, misaligned;
    logic [31:0] wb_data, wb_rdest;

    mem_stage_if #(.DATA_W(32)) bus ();

    mem_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .pipe_en(pipe_en),
        .ALUres(alu), .Bout(bout), .NPC4_IN(npc4), .cwMEM(cw), .Rdest_in(rdest),
        .dmem(bus.master),
        .stall(stall), .wb_data(wb_data), .wb_rdest(wb_rdest),
        .wb_en(wb_en), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] rdest;
        logic        en;
        logic        mis;
        bit          chk_data;
    } wb_t;

    wb_t sb_q[$];
    int  vec  = 0;
    int  errs = 0;

    // Drives one EX/MEM instruction until it completes. The memory grants
    // on the (gw+1)-th request cycle and returns rvalid rw cycles after a
    // load grant. Returns activity counts for the calling scenario to check.
    task automatic issue(input logic [6:0] c, input logic [31:0] a, b, d,
                         input int gw, rw, input logic [31:0] rd,
                         output int rq, gn, st, bb, un, output bit tmo,
                         output logic [31:0] wd, output logic [3:0] bes);
        int n, seen, since;
        bit done, s;
        logic [31:0] a0, w0;
        logic [3:0]  be0;
        logic        we0;
        rq = 0; gn = 0; st = 0; bb = 0; un = 0; tmo = 0; wd = '0; bes = '0;
        n = 0; seen = 0; since = -1; done = 0;
        a0 = '0; w0 = '0; be0 = '0; we0 = 1'b0;
        cw = c; alu = a; bout = b; rdest = d;
        while (!done && n < 40) begin
            bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
            if (since >= 0) since++;
            if (rw > 0 && since == rw) begin
                bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rd;
            end
            #1;
            if (bus.dmem_req) begin
                if (rq == 0) begin
                    a0 = bus.dmem_addr; w0 = bus.dmem_wdata;
                    be0 = bus.dmem_be; we0 = bus.dmem_we;
                    wd = w0; bes = be0;
                end else if ({bus.dmem_addr, bus.dmem_wdata, bus.dmem_be, bus.dmem_we}
                             !== {a0, w0, be0, we0}) begin
                    un++;
                end
                rq++;
                if (seen >= gw) begin
                    bus.dmem_gnt = 1'b1; gn++;
                    if (c[6]) since = 0;
                end
                seen++;
            end
            #1;
            s = stall;
            pipe_en = !s;
            @(posedge clk); #2;
            if (s) begin
                st++;
                if (wb_en !== 1'b0) bb++;
            end else begin
                done = 1;
            end
            n++;
        end
        tmo = !done;
        cw = 7'd0; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; pipe_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pipe_en = 1'b1; cw = 7'h52; alu = 32'h100; bout = '0;
        npc4 = '0; rdest = 32'd3;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        vec++;
        if ({bus.dmem_req, stall, wb_data, wb_rdest, wb_en, misaligned} !== 68'd0) begin
            errs++;
            $display("FAIL reset_state: req=%b stall=%b data=%h rdest=%h en=%b mis=%b, all must be 0",
                     bus.dmem_req, stall, wb_data, wb_rdest, wb_en, misaligned);
        end
        cw = 7'd0;
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_word_load();
        int rq, gn, st, bb, un; bit tmo; logic [31:0] wd; logic [3:0] bes; wb_t e;
        sb_q.push_back('{32'hDEADBEEF, 32'd5, 1'b1, 1'b0, 1'b1});
        issue(7'h52, 32'h100, 32'h0, 32'd5, 0, 1, 32'hDEADBEEF, rq, gn, st, bb, un, tmo, wd, bes);
        e = sb_q.pop_front();
        vec++;
        if ({tmo, rq, st} !== {1'b0, 32'd1, 32'd1}) begin
            errs++;
            $display("FAIL word_load_timing: tmo=%0d req_cycles=%0d stalls=%0d, want 0/1/1", tmo, rq, st);
        end
        vec++;
        if ({wb_data, wb_rdest, wb_en, misaligned} !== {e.data, e.rdest, e.en, e.mis}) begin
            errs++;
            $display("FAIL word_load_wb: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                     wb_data, wb_rdest, wb_en, misaligned, e.data, e.rdest, e.en, e.mis);
        end
    endtask

    task automatic test_load_ext();
        logic [6:0]  cws [3] = '{7'h42, 7'h46, 7'h4A};
        logic [31:0] adr [3] = '{32'h103, 32'h103, 32'h102};
        logic [31:0] want[3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011};
        int rq, gn, st, bb, un; bit tmo; logic [31:0] wd; logic [3:0] bes; wb_t e;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{want[i], 32'(10 + i), 1'b1, 1'b0, 1'b1});
            issue(cws[i], adr[i], 32'h0, 32'(10 + i), 0, 1, 32'h80112233,
                  rq, gn, st, bb, un, tmo, wd, bes);
            e = sb_q.pop_front();
            vec++;
            if (tmo || {wb_data, wb_rdest, wb_en, misaligned} !== {e.data, e.rdest, e.en, e.mis}) begin
                errs++;
                $display("FAIL load_ext_%0d: tmo=%0d got %h/%0d/%b/%b want %h/%0d/%b/%b", i, tmo,
                         wb_data, wb_rdest, wb_en, misaligned, e.data, e.rdest, e.en, e.mis);
            end
        end
    endtask

    task automatic test_half_store();
        int rq, gn, st, bb, un; bit tmo; logic [31:0] wd; logic [3:0] bes; wb_t e;
        sb_q.push_back('{32'h0, 32'd7, 1'b0, 1'b0, 1'b0});
        issue(7'h28, 32'h206, 32'h0000ABCD, 32'd7, 3, 0, 32'h0, rq, gn, st, bb, un, tmo, wd, bes);
        e = sb_q.pop_front();
        vec++;
        if ({tmo, rq, gn, st, un} !== {1'b0, 32'd4, 32'd1, 32'd3, 32'd0}) begin
            errs++;
            $display("FAIL half_store_handshake: tmo=%0d req_cycles=%0d grants=%0d stalls=%0d unstable=%0d, want 0/4/1/3/0",
                     tmo, rq, gn, st, un);
        end
        vec++;
        if ({wd, bes} !== {32'hABCDABCD, 4'b1100}) begin
            errs++;
            $display("FAIL half_store_lanes: wdata=%h be=%b want ABCDABCD/1100", wd, bes);
        end
        vec++;
        if (bb !== 0) begin
            errs++;
            $display("FAIL half_store_bubbles: %0d stall cycles had wb_en=1, want 0", bb);
        end
        vec++;
        if ({wb_rdest, wb_en, misaligned} !== {e.rdest, e.en, e.mis}) begin
            errs++;
            $display("FAIL half_store_wb: got %0d/%b/%b want %0d/%b/%b",
                     wb_rdest, wb_en, misaligned, e.rdest, e.en, e.mis);
        end
    endtask

    task automatic test_byte_store();
        int rq, gn, st, bb, un; bit tmo; logic [31:0] wd; logic [3:0] bes;
        issue(7'h20, 32'h302, 32'h123456EF, 32'd8, 0, 0, 32'h0, rq, gn, st, bb, un, tmo, wd, bes);
        vec++;
        if ({tmo, rq, st, wd, bes} !== {1'b0, 32'd1, 32'd0, 32'hEFEFEFEF, 4'b0100}) begin
            errs++;
            $display("FAIL byte_store: tmo=%0d req_cycles=%0d stalls=%0d wdata=%h be=%b want 0/1/0/EFEFEFEF/0100",
                     tmo, rq, st, wd, bes);
        end
    endtask

    task automatic test_misaligned();
        int rq, gn, st, bb, un; bit tmo; logic [31:0] wd; logic [3:0] bes; wb_t e;
        sb_q.push_back('{32'h0, 32'd12, 1'b0, 1'b1, 1'b0});
        issue(7'h52, 32'h101, 32'h0, 32'd12, 0, 1, 32'h11111111, rq, gn, st, bb, un, tmo, wd, bes);
        e = sb_q.pop_front();
        vec++;
        if ({tmo, rq, st} !== {1'b0, 32'd0, 32'd0}) begin
            errs++;
            $display("FAIL misaligned_noreq: tmo=%0d req_cycles=%0d stalls=%0d want 0/0/0", tmo, rq, st);
        end
        vec++;
        if ({wb_rdest, wb_en, misaligned} !== {e.rdest, e.en, e.mis}) begin
            errs++;
            $display("FAIL misaligned_wb: got %0d/%b/%b want %0d/%b/%b",
                     wb_rdest, wb_en, misaligned, e.rdest, e.en, e.mis);
        end
    endtask

    task automatic test_alu_npc();
        int rq, gn, st, bb, un; bit tmo; logic [31:0] wd; logic [3:0] bes; wb_t e;
        npc4 = 32'h0000_2004;
        sb_q.push_back('{32'h0BAD_0001, 32'd14, 1'b1, 1'b0, 1'b1});
        issue(7'h01, 32'h0BAD_0001, 32'h0, 32'd14, 0, 0, 32'h0, rq, gn, st, bb, un, tmo, wd, bes);
        e = sb_q.pop_front();
        vec++;
        if (tmo || rq != 0 || {wb_data, wb_rdest, wb_en, misaligned} !== {e.data, e.rdest, e.en, e.mis}) begin
            errs++;
            $display("FAIL alu_wb: tmo=%0d req_cycles=%0d got %h/%0d/%b want %h/%0d/%b",
                     tmo, rq, wb_data, wb_rdest, wb_en, e.data, e.rdest, e.en);
        end
        sb_q.push_back('{32'h0000_2004, 32'd15, 1'b1, 1'b0, 1'b1});
        issue(7'h03, 32'h0000_0777, 32'h0, 32'd15, 0, 0, 32'h0, rq, gn, st, bb, un, tmo, wd, bes);
        e = sb_q.pop_front();
        vec++;
        if (tmo || {wb_data, wb_rdest, wb_en, misaligned} !== {e.data, e.rdest, e.en, e.mis}) begin
            errs++;
            $display("FAIL npc4_wb: tmo=%0d got %h/%0d/%b want %h/%0d/%b",
                     tmo, wb_data, wb_rdest, wb_en, e.data, e.rdest, e.en);
        end
    endtask

    task automatic test_hold();
        cw = 7'h01; alu = 32'h5555_AAAA; rdest = 32'd20; pipe_en = 1'b0;
        @(posedge clk); #2;
        vec++;
        if ({wb_data, wb_rdest, wb_en} !== {32'h0000_2004, 32'd15, 1'b1}) begin
            errs++;
            $display("FAIL hold_frozen: got %h/%0d/%b want 00002004/15/1", wb_data, wb_rdest, wb_en);
        end
        cw = 7'd0; pipe_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int rq1, gn1, st1, rq2, gn2, st2, bb, un; bit t1, t2; logic [31:0] wd; logic [3:0] bes; wb_t e;
        issue(7'h30, 32'h300, 32'h12345678, 32'd0, 0, 0, 32'h0, rq1, gn1, st1, bb, un, t1, wd, bes);
        vec++;
        if ({wd, bes, st1} !== {32'h12345678, 4'b1111, 32'd0}) begin
            errs++;
            $display("FAIL b2b_store: wdata=%h be=%b stalls=%0d want 12345678/1111/0", wd, bes, st1);
        end
        sb_q.push_back('{32'hCAFEF00D, 32'd9, 1'b1, 1'b0, 1'b1});
        issue(7'h52, 32'h300, 32'h0, 32'd9, 0, 2, 32'hCAFEF00D, rq2, gn2, st2, bb, un, t2, wd, bes);
        e = sb_q.pop_front();
        vec++;
        if ({t1, t2, rq1 + rq2, gn1 + gn2, st2} !== {2'b00, 32'd2, 32'd2, 32'd2}) begin
            errs++;
            $display("FAIL b2b_requests: tmo=%0d%0d req_cycles=%0d grants=%0d load_stalls=%0d want 00/2/2/2",
                     t1, t2, rq1 + rq2, gn1 + gn2, st2);
        end
        vec++;
        if ({wb_data, wb_rdest, wb_en, misaligned} !== {e.data, e.rdest, e.en, e.mis}) begin
            errs++;
            $display("FAIL b2b_load_wb: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                     wb_data, wb_rdest, wb_en, misaligned, e.data, e.rdest, e.en, e.mis);
        end
    endtask

    task automatic test_reset_mid_access();
        int rq, gn, st, bb, un; bit tmo; logic [31:0] wd; logic [3:0] bes; wb_t e;
        // Load granted immediately, then reset while waiting for rvalid.
        cw = 7'h52; alu = 32'h400; rdest = 32'd21; pipe_en = 1'b0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        #1;
        bus.dmem_gnt = bus.dmem_req;
        @(posedge clk); #2;
        bus.dmem_gnt = 1'b0;
        #1;
        vec++;
        if (stall !== 1'b1) begin
            errs++;
            $display("FAIL wait_r_stall: stall=%b want 1", stall);
        end
        rst = 1'b1;
        #1;
        vec++;
        if ({bus.dmem_req, stall, wb_data, wb_rdest, wb_en, misaligned} !== 68'd0) begin
            errs++;
            $display("FAIL reset_mid_access: req=%b stall=%b data=%h rdest=%h en=%b mis=%b, all must be 0",
                     bus.dmem_req, stall, wb_data, wb_rdest, wb_en, misaligned);
        end
        cw = 7'd0;
        @(posedge clk); #3;
        rst = 1'b0; pipe_en = 1'b1;
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h5555_5555;
        #1;
        vec++;
        if ({bus.dmem_req, stall} !== 2'b00) begin
            errs++;
            $display("FAIL stale_rvalid: req=%b stall=%b want 0/0", bus.dmem_req, stall);
        end
        @(posedge clk); #2;
        bus.dmem_rvalid = 1'b0;
        sb_q.push_back('{32'h0BADF00D, 32'd22, 1'b1, 1'b0, 1'b1});
        issue(7'h52, 32'h400, 32'h0, 32'd22, 0, 1, 32'h0BADF00D, rq, gn, st, bb, un, tmo, wd, bes);
        e = sb_q.pop_front();
        vec++;
        if (tmo || rq != 1 || st != 1 ||
            {wb_data, wb_rdest, wb_en, misaligned} !== {e.data, e.rdest, e.en, e.mis}) begin
            errs++;
            $display("FAIL post_reset_load: tmo=%0d req_cycles=%0d stalls=%0d got %h/%0d/%b want %h/%0d/%b",
                     tmo, rq, st, wb_data, wb_rdest, wb_en, e.data, e.rdest, e.en);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_load_ext();
        test_half_store();
        test_byte_store();
        test_misaligned();
        test_alu_npc();
        test_hold();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
